// File: rtl/servo_bank.sv
// servo_bank: multi-channel hobby-servo PWM generator.
// A shared prescaler produces a tick every DIV clocks; a frame counter counts
// ticks; each channel compares the frame counter against OFFSET + position.
// Positions are double-buffered (shadow -> cur) and only move at the frame
// boundary, optionally slew-limited, so pulses are never cut or stretched.
// load[i] is a single-cycle capture strobe with no back-pressure: every cycle
// it is high, that channel's pos slice is written into its shadow register.
module servo_bank #(
  parameter int CH           = 4,
  parameter int PW           = 8,
  parameter int DIV          = 93,
  parameter int PERIOD_TICKS = 2048,
  parameter int OFFSET       = 46,
  parameter int SLEW         = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH*PW-1:0] pos,
  input  logic [CH-1:0]    load,
  input  logic [CH-1:0]    en,
  output logic [CH-1:0]    servo,
  output logic             frame
);

  localparam int TW = $clog2(PERIOD_TICKS);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int MW = (PW + 1 > TW) ? PW + 1 : TW;
  // Comparison width: wide enough that OFFSET + position never wraps.
  localparam int SW = MW + 1;
  // A slew step at or above the full position range can never bind.
  localparam bit LIMIT = (SLEW != 0) && (SLEW < (1 << PW));
  localparam logic signed [PW+1:0] SLEW_S = (PW+2)'(SLEW);

  // Reject parameter sets where the widest pulse would not end inside the frame.
  if (OFFSET + (1 << PW) - 1 >= PERIOD_TICKS) begin : g_bad_offset
    $error("servo_bank: OFFSET + 2**PW - 1 must be below PERIOD_TICKS");
  end
  if ((PERIOD_TICKS & (PERIOD_TICKS - 1)) != 0) begin : g_bad_period
    $error("servo_bank: PERIOD_TICKS must be a power of two");
  end

  logic [DW-1:0]         presc;
  logic [TW-1:0]         tick_cnt;
  logic                  tick;
  logic                  upd;
  logic [PW-1:0]         shadow   [CH];
  logic [PW-1:0]         cur      [CH];
  logic [PW-1:0]         cur_next [CH];
  logic signed [PW+1:0]  diff     [CH];
  logic [SW-1:0]         pulse_end[CH];
  logic [CH-1:0]         en_q;
  logic [CH-1:0]         servo_next;

  assign tick = (presc == DW'(DIV - 1));
  // Update event: the last tick of the frame.
  assign upd  = tick && (tick_cnt == TW'(PERIOD_TICKS - 1));

  // Next frame position per channel: jump to shadow, or step toward it by SLEW.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      diff[i]     = $signed({2'b00, shadow[i]}) - $signed({2'b00, cur[i]});
      cur_next[i] = shadow[i];
      if (LIMIT) begin
        if (diff[i] > SLEW_S) begin
          cur_next[i] = cur[i] + PW'(SLEW);
        end else if (diff[i] < -SLEW_S) begin
          cur_next[i] = cur[i] - PW'(SLEW);
        end
      end
    end
  end

  // Pulse comparator: high while the frame counter is below OFFSET + position.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      pulse_end[i]  = SW'(OFFSET) + {{(SW-PW){1'b0}}, cur[i]};
      servo_next[i] = en_q[i] && ({{(SW-TW){1'b0}}, tick_cnt} < pulse_end[i]);
    end
  end

  // Timebase: prescaler, frame tick counter and the registered frame strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      tick_cnt <= '0;
      frame    <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + DW'(1);
      if (tick) begin
        tick_cnt <= tick_cnt + TW'(1);
      end
      frame <= upd;
    end
  end

  // Channel state: shadow capture any time, cur/en_q only on the update event.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q <= '0;
      for (int i = 0; i < CH; i++) begin
        shadow[i] <= '0;
        cur[i]    <= '0;
      end
    end else begin
      if (upd) begin
        en_q <= en;
      end
      for (int i = 0; i < CH; i++) begin
        if (load[i]) begin
          shadow[i] <= pos[i*PW +: PW];
        end
        if (upd) begin
          cur[i] <= cur_next[i];
        end
      end
    end
  end

  // Registered PWM outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      servo <= '0;
    end else begin
      servo <= servo_next;
    end
  end

endmodule

// File: tb/tb_servo_bank.sv
// Directed bench for servo_bank: CH=2, PW=4, DIV=4, PERIOD_TICKS=64, OFFSET=4.
// Frame = 256 clk; a width of N ticks is N*4 clk of high time.
// dut runs unlimited slew; dut_s runs SLEW=2 from the same clock and reset.
module tb_servo_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pos, pos_s;
  logic [1:0] load, en, load_s, en_s;
  logic [1:0] servo, servo_s;
  logic       frame, frame_s;

  int total    = 0;
  int passed   = 0;
  int c0       = 0;
  int c1       = 0;
  int cs       = 0;
  int since    = 0;
  int w0       = 0;
  int w1       = 0;
  int ws       = 0;
  int gap      = 0;
  int frame_no = 0;

  logic [15:0] exp_q[$];

  servo_bank #(.CH(2), .PW(4), .DIV(4), .PERIOD_TICKS(64), .OFFSET(4), .SLEW(0)) dut (
    .clk(clk), .rst(rst), .pos(pos), .load(load), .en(en), .servo(servo), .frame(frame)
  );

  servo_bank #(.CH(2), .PW(4), .DIV(4), .PERIOD_TICKS(64), .OFFSET(4), .SLEW(2)) dut_s (
    .clk(clk), .rst(rst), .pos(pos_s), .load(load_s), .en(en_s), .servo(servo_s),
    .frame(frame_s)
  );

  // Clock
  always #5 clk = ~clk;

  // Width monitor: high clk count of each output over the frame that just ended.
  always @(negedge clk) begin
    if (frame) begin
      w0  = c0;
      w1  = c1;
      ws  = cs;
      gap = since;
      frame_no++;
      c0    = 0;
      c1    = 0;
      cs    = 0;
      since = 1;
    end else begin
      c0 += int'(servo[0]);
      c1 += int'(servo[1]);
      cs += int'(servo_s[0]);
      since++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Wait until the monitor has seen frame pulse number n (bounded).
  task automatic wait_for(input int n);
    int k;
    k = 0;
    while (frame_no < n && k < 600) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (frame_no < n) check("frame_timeout", frame_no, n);
  endtask

  initial begin
    int k;
    bit found;

    rst    = 1'b1;
    pos    = '0;
    load   = '0;
    en     = '0;
    pos_s  = '0;
    load_s = '0;
    en_s   = '0;
    step(3);
    check("rst_servo", int'(servo), 0);
    check("rst_frame", int'(frame), 0);
    check("rst_servo_s", int'(servo_s), 0);

    // Basic widths and slew ramp: ch0=5, ch1=0; slew instance ch0 -> 15.
    rst    = 1'b0;
    en     = 2'b11;
    pos    = 8'h05;
    load   = 2'b11;
    en_s   = 2'b01;
    pos_s  = 8'h0F;
    load_s = 2'b01;
    step(1);
    load   = 2'b00;
    load_s = 2'b00;
    exp_q  = '{16'd24, 16'd32, 16'd40, 16'd48, 16'd56, 16'd64, 16'd72, 16'd76, 16'd76};
    wait_for(1);
    for (int f = 2; f <= 10; f++) begin
      wait_for(f);
      check("slew_ch0", ws, int'(exp_q.pop_front()));
      check("width_ch0", w0, 36);
      check("width_ch1", w1, 16);
      check("frame_gap", gap, 256);
    end

    // Mid-frame load at tick_cnt=3: current frame keeps 9 ticks.
    step(12);
    pos  = 8'h0A;
    load = 2'b01;
    step(1);
    load = 2'b00;
    wait_for(11);
    check("midload_cur", w0, 36);
    wait_for(12);
    check("midload_next", w0, 56);

    // Load coincident with the update event: old shadow 5, new 12.
    pos  = 8'h05;
    load = 2'b01;
    step(1);
    load = 2'b00;
    wait_for(13);
    check("coinc_setup", w0, 56);
    step(255);
    pos  = 8'h0C;
    load = 2'b01;
    step(1);
    load = 2'b00;
    check("coinc_align", int'(frame), 1);
    wait_for(14);
    check("coinc_prev", w0, 36);
    wait_for(15);
    check("coinc_next", w0, 36);
    wait_for(16);
    check("coinc_after", w0, 64);

    // Enable drop at tick_cnt=2 while ch0=5.
    pos  = 8'h05;
    load = 2'b01;
    step(1);
    load = 2'b00;
    wait_for(17);
    check("en_setup", w0, 64);
    step(8);
    en = 2'b10;
    wait_for(18);
    check("en_drop_cur", w0, 36);
    check("en_drop_ch1", w1, 16);
    wait_for(19);
    check("en_off", w0, 0);
    en = 2'b11;
    wait_for(20);
    check("en_off_pending", w0, 0);
    wait_for(21);
    check("en_restore", w0, 36);

    // Reset mid-pulse at tick_cnt=3.
    step(12);
    check("pre_rst_servo0", int'(servo[0]), 1);
    rst = 1'b1;
    step(1);
    check("midrst_servo", int'(servo), 0);
    check("midrst_frame", int'(frame), 0);
    check("midrst_servo_s", int'(servo_s), 0);
    rst   = 1'b0;
    k     = 0;
    found = 1'b0;
    while (!found && k < 600) begin
      @(negedge clk);
      #1;
      k++;
      if (frame) found = 1'b1;
    end
    check("rst_frame_delay", k, 256);
    step(1);
    check("frame_one_clk", int'(frame), 0);
    wait_for(23);
    check("rst_ch0_min", w0, 16);
    check("rst_ch1_min", w1, 16);
    check("rst_frame_gap", gap, 256);
    pos  = 8'h05;
    load = 2'b01;
    step(1);
    load = 2'b00;
    wait_for(24);
    check("reload_pending", w0, 16);
    wait_for(25);
    check("reload_applied", w0, 36);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
